// File: rtl/cmd_decoder.sv
// ============================================================================
// cmd_decoder : byte-stream command decoder driving register write/read strobes
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cmd_decoder #(
  parameter int DATA_BYTES     = 4,
  parameter int NUM_REGS       = 16,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int IDX_W          = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic [NUM_REGS-1:0] write,
  output logic [NUM_REGS-1:0] write_done,
  output logic [IDX_W-1:0]    write_byte,
  output logic [7:0]          wr_data,
  output logic                read_req,
  output logic [6:0]          read_addr,
  output logic                busy,
  output logic                err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NUM_REGS-1:0] REG_ONE  = NUM_REGS'(1);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DATA_BYTES - 1);
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DISCARD = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [6:0]         addr, addr_nxt;
  logic [IDX_W-1:0]   byte_idx, byte_idx_nxt;
  logic [TMR_W-1:0]   tmr, tmr_nxt;
  logic [NUM_REGS-1:0] write_nxt, write_done_nxt;
  logic [IDX_W-1:0]   write_byte_nxt;
  logic [7:0]         wr_data_nxt;
  logic               read_req_nxt;
  logic [6:0]         read_addr_nxt;
  logic               err_nxt;
  logic [6:0]         cmd_addr;
  logic               cmd_addr_ok;

  assign cmd_addr    = rx_data[6:0];
  assign cmd_addr_ok = ({1'b0, cmd_addr} < 8'(NUM_REGS));

  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr;
    byte_idx_nxt   = byte_idx;
    tmr_nxt        = tmr;
    write_nxt      = '0;
    write_done_nxt = '0;
    write_byte_nxt = write_byte;
    wr_data_nxt    = wr_data;
    read_req_nxt   = 1'b0;
    read_addr_nxt  = read_addr;
    err_nxt        = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (state == DONE) begin
          write_done_nxt = REG_ONE << addr;
        end
        state_nxt = IDLE;
        // DONE decodes a command byte exactly like IDLE so back-to-back frames lose nothing
        if (rx_valid) begin
          if (rx_data[7]) begin
            addr_nxt     = cmd_addr;
            byte_idx_nxt = '0;
            tmr_nxt      = '0;
            state_nxt    = cmd_addr_ok ? PAYLOAD : DISCARD;
          end else if (cmd_addr_ok) begin
            read_req_nxt  = 1'b1;
            read_addr_nxt = cmd_addr;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      PAYLOAD, DISCARD: begin
        if (rx_valid) begin
          tmr_nxt      = '0;
          byte_idx_nxt = byte_idx + 1'b1;
          if (state == PAYLOAD) begin
            write_nxt      = REG_ONE << addr;
            write_byte_nxt = byte_idx;
            wr_data_nxt    = rx_data;
          end
          if (byte_idx == LAST_IDX) begin
            state_nxt = (state == PAYLOAD) ? DONE : IDLE;
            err_nxt   = (state == DISCARD);
          end
        end else if (tmr == TMR_LAST) begin
          // A byte on the expiry cycle takes priority over the timeout
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      byte_idx   <= '0;
      tmr        <= '0;
      write      <= '0;
      write_done <= '0;
      write_byte <= '0;
      wr_data    <= '0;
      read_req   <= 1'b0;
      read_addr  <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      byte_idx   <= byte_idx_nxt;
      tmr        <= tmr_nxt;
      write      <= write_nxt;
      write_done <= write_done_nxt;
      write_byte <= write_byte_nxt;
      wr_data    <= wr_data_nxt;
      read_req   <= read_req_nxt;
      read_addr  <= read_addr_nxt;
      busy       <= (state_nxt != IDLE);
      err        <= err_nxt;
    end
  end

endmodule

`default_nettype wire

// File: doc/cmd_decoder.md
CMD_DECODER -- requirements
Module: cmd_decoder

Interface
REQ-001 Parameter DATA_BYTES, default 4: payload bytes per register write.
REQ-002 Parameter NUM_REGS, default 16: number of addressable registers, at most 128.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000: idle clock cycles allowed between payload bytes.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 rx_valid  in  1  one-cycle strobe; rx_data is valid on this cycle.
REQ-007 rx_data  in  8  received byte.
REQ-008 write  out  NUM_REGS  one-hot write strobe; bit i drives register i.
REQ-009 write_done  out  NUM_REGS  one-hot end-of-write strobe per register.
REQ-010 write_byte  out  $clog2(DATA_BYTES)  byte index of the current write strobe.
REQ-011 wr_data  out  8  byte value of the current write strobe.
REQ-012 read_req  out  1  one-cycle read request.
REQ-013 read_addr  out  7  register address of read_req; held until the next read_req.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 err  out  1  one-cycle error strobe.

Function
REQ-016 Frame format SHALL be: command byte, then DATA_BYTES payload bytes for writes only; command bit7 = 1 means write, 0 means read; bits6:0 are the address.
REQ-017 States SHALL be IDLE, PAYLOAD, DISCARD and DONE.
REQ-018 IDLE, valid-address write command: latch the address, clear byte_idx, go to PAYLOAD.
REQ-019 IDLE, read command, address < NUM_REGS: next cycle read_req=1 and read_addr=address; stay in IDLE.
REQ-020 IDLE, address >= NUM_REGS: a read pulses err next cycle; a write goes to DISCARD.
REQ-021 PAYLOAD, per rx_valid: next cycle write[addr]=1, write_byte=byte_idx, wr_data=rx_data for exactly one cycle; then byte_idx increments.
REQ-022 Payload order SHALL be LSB first: byte index 0 first, index DATA_BYTES-1 last.
REQ-023 On the last payload byte, go to DONE; DONE lasts one cycle and asserts write_done[addr] on the cycle after the last write strobe.
REQ-024 rx_valid during DONE SHALL be decoded as a command byte, exactly as in IDLE.
REQ-025 DISCARD: consume DATA_BYTES bytes with no write strobes; after the last byte, pulse err and return to IDLE.
REQ-026 Timeout counter: cleared on every rx_valid and on entry to PAYLOAD or DISCARD; counts while in PAYLOAD or DISCARD.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES: pulse err, return to IDLE, no write_done; bytes already written SHALL NOT be undone.
REQ-028 rx_valid on the same cycle the timeout is reached: the byte SHALL be accepted and the timeout ignored.
REQ-029 write and write_done SHALL never have more than one bit set, and SHALL never both be set on the same cycle.
REQ-030 All outputs SHALL be registered; latency from the rx_valid edge to the resulting strobe is exactly 1 cycle.

Reset
REQ-031 Reset SHALL force state to IDLE and clear byte_idx and the timeout counter.
REQ-032 Reset SHALL drive write=0, write_done=0, write_byte=0, wr_data=0, read_req=0, read_addr=0, busy=0 and err=0 on the following cycle.
REQ-033 Reset during PAYLOAD SHALL abort the frame with no write_done; the next byte after reset SHALL be treated as a command byte.

Verification
(Bench parameters: DATA_BYTES=4, NUM_REGS=16, TIMEOUT_CYCLES=100.)
REQ-034 Bytes 0x83,0x11,0x22,0x33,0x44 -> write[3] strobes with (write_byte,wr_data) = (0,0x11), (1,0x22), (2,0x33), (3,0x44); then write_done=0x0008 one cycle after the last strobe; busy low after that.
REQ-035 Byte 0x05 -> read_req=1 and read_addr=5 one cycle later, for one cycle; no write activity.
REQ-036 Bytes 0x9F then 4 payload bytes -> no write strobes; err pulses once after the 4th byte. Byte 0x20 -> err pulses next cycle; no read_req.
REQ-037 Bytes 0x81,0xAA, then 100 idle cycles -> err pulses; no write_done; next byte 0x02 -> read_req with read_addr=2.
REQ-038 Bytes 0x81,0xAA,0xBB, then reset for 1 cycle -> all outputs 0; bytes 0x81,1,2,3,4 then complete normally with write_done=0x0002.
REQ-039 Last payload byte of a frame to reg 1, then 0x07 arriving during DONE -> write_done[1] and the decode of 0x07 both occur, with read_req/read_addr=7 on the next cycle.
